macro_lane_pipe: RTL and testbench

// - Parametrised multi-lane macro pipeline: LANES independent lanes of WIDTH bits pass through STAGES registered slots.
// - One slot (MIX_STAGE) applies a lane permutation, as the wide NxN macro stage does between narrow per-lane stages.
// - Valid/ready backpressure and an occupancy count. Used as a synthesisable, macro-dense placement testcase.

---
 rtl/macro_lane_pipe_pkg.sv | 42 ++++
 rtl/macro_lane_pipe_if.sv | 29 ++
 rtl/macro_lane_pipe_stage.sv | 58 +++++
 rtl/macro_lane_pipe.sv | 87 ++++++++
 tb/tb_macro_lane_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/macro_lane_pipe_pkg.sv
// Shared types and the lane permutation helper for the macro lane pipeline.
// The permutation works on a fixed-width container so one function serves every LANES/WIDTH.
package macro_pipe_pkg;

    typedef enum logic [1:0] {
        MIX_PASS     = 2'd0,
        MIX_ROTL     = 2'd1,
        MIX_REV      = 2'd2,
        MIX_PAIRSWAP = 2'd3
    } mix_mode_e;

    // Upper bound on LANES*WIDTH; callers zero-extend into and slice out of this container.
    localparam int MAX_BITS = 256;

    function automatic logic [MAX_BITS-1:0] lane_permute(
        input logic [MAX_BITS-1:0] data,
        input mix_mode_e           mode,
        input int                  lanes,
        input int                  width
    );
        logic [MAX_BITS-1:0] res;
        int k;
        int j;
        int src;
        res = '0;
        for (int b = 0; b < MAX_BITS; b++) begin
            if (b < lanes * width) begin
                k = b / width;
                j = b % width;
                case (mode)
                    MIX_ROTL:     src = (k + 1) % lanes;
                    MIX_REV:      src = lanes - 1 - k;
                    MIX_PAIRSWAP: src = k ^ 1;
                    default:      src = k;
                endcase
                res[b] = data[src * width + j];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/macro_lane_pipe_if.sv
// Upstream/downstream handshake bundle of the macro lane pipeline.
// master = traffic source/sink around the pipe, slave = the pipe itself.
interface macro_lane_pipe_if
    import macro_pipe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WIDTH  = 1,
    parameter int STAGES = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*WIDTH-1:0]        in_data;
    mix_mode_e                     mix_mode;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*WIDTH-1:0]        out_data;
    logic [$clog2(STAGES+1)-1:0]   occupancy;
    logic                          busy;

    modport master (
        output in_valid, in_data, mix_mode, out_ready,
        input  in_ready, out_valid, out_data, occupancy, busy
    );

    modport slave (
        input  in_valid, in_data, mix_mode, out_ready,
        output in_ready, out_valid, out_data, occupancy, busy
    );
endinterface

// File: rtl/macro_lane_pipe_stage.sv
// One registered pipeline slot: valid, lane data and the mode travelling with the beat.
// With PERMUTE set, the slot's data output is lane-permuted by its own stored mode.
module macro_lane_stage
    import macro_pipe_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int WIDTH   = 1,
    parameter bit PERMUTE = 1'b0
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_valid,
    input  logic [LANES*WIDTH-1:0] up_data,
    input  mix_mode_e              up_mode,
    input  logic                   down_ready,
    output logic                   valid,
    output logic [LANES*WIDTH-1:0] data,
    output mix_mode_e              mode
);
    localparam int DW = LANES * WIDTH;

    logic          valid_q;
    logic [DW-1:0] data_q;
    mix_mode_e     mode_q;
    logic          load;

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign load = !valid_q || down_ready;

    // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
    // NOTE: data and mode are reset too, so out_data reads 0 (never X) straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= MIX_PASS;
        end else if (load) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
                mode_q <= up_mode;
            end
        end
    end

    generate
        if (PERMUTE) begin : g_mix
            logic [MAX_BITS-DW-1:0] perm_unused;
            assign {perm_unused, data} = lane_permute(MAX_BITS'(data_q), mode_q, LANES, WIDTH);
        end else begin : g_pass
            assign data = data_q;
        end
    endgenerate

    assign valid = valid_q;
    assign mode  = mode_q;
endmodule

// File: rtl/macro_lane_pipe.sv
// Multi-lane valid/ready pipeline of STAGES slots with one lane-permuting slot and an occupancy count.
// The ready chain is resolved back to front in one combinational block, so a full pipe streams without bubbles.
module macro_lane_pipe
    import macro_pipe_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int WIDTH     = 1,
    parameter int STAGES    = 3,
    parameter int MIX_STAGE = 1
)
(
    input  logic              clk,
    input  logic              rst,
    macro_lane_pipe_if.slave  bus
);
    localparam int DW = LANES * WIDTH;
    localparam int OW = $clog2(STAGES + 1);

    // Index 0 is the upstream port; slot i drives index i+1.
    logic [STAGES:0] chain_valid;
    logic [DW-1:0]   chain_data [STAGES+1];
    mix_mode_e       chain_mode [STAGES+1];
    logic [STAGES-1:0] down_ready;
    logic            in_ready_c;
    logic            accept;
    logic            emit;
    logic [OW-1:0]   occ_q;
    logic            unused_mode;

    assign chain_valid[0] = bus.in_valid;
    assign chain_data[0]  = bus.in_data;
    assign chain_mode[0]  = bus.mix_mode;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic r;
        down_ready = '0;
        r          = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            down_ready[i] = r;
            r = !chain_valid[i+1] || r;
        end
        in_ready_c = r;
    end

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_slot
            macro_lane_stage #(
                .LANES   (LANES),
                .WIDTH   (WIDTH),
                .PERMUTE (i == MIX_STAGE)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .up_valid   (chain_valid[i]),
                .up_data    (chain_data[i]),
                .up_mode    (chain_mode[i]),
                .down_ready (down_ready[i]),
                .valid      (chain_valid[i+1]),
                .data       (chain_data[i+1]),
                .mode       (chain_mode[i+1])
            );
        end
    endgenerate

    assign accept = bus.in_valid && in_ready_c;
    assign emit   = chain_valid[STAGES] && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (accept && !emit) begin
            occ_q <= occ_q + 1'b1;
        end else if (emit && !accept) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    // The mode leaving the last slot has no consumer.
    assign unused_mode = ^{chain_mode[STAGES]};

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = chain_valid[STAGES];
    assign bus.out_data  = chain_data[STAGES];
    assign bus.occupancy = occ_q;
    assign bus.busy      = (occ_q != '0);
endmodule

// File: tb/tb_macro_lane_pipe.sv
// Directed bench for macro_lane_pipe at default parameters: mode table plus
// hand-written reset, latency, backpressure, full-throughput and mid-flight reset sequences.
module tb_macro_lane_pipe;
    import macro_pipe_pkg::*;

    localparam int LANES     = 4;
    localparam int WIDTH     = 1;
    localparam int STAGES    = 3;
    localparam int MIX_STAGE = 1;
    localparam int NVEC      = 8;

    typedef struct {
        logic [3:0] data;
        mix_mode_e  mode;
        logic [3:0] expect_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    macro_lane_pipe_if #(.LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES)) bus ();

    macro_lane_pipe #(
        .LANES     (LANES),
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .MIX_STAGE (MIX_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int n_acc  = 0;
    int n_emt  = 0;
    logic [3:0] sb [$];
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: sample handshakes before the edge, score emits against accepted beats.
    task automatic cycle(input logic v, input logic [3:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.mix_mode  = MIX_PASS;
        bus.out_ready = r;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_emt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL emit_unexpected: got beat 0x%0h, want no beat", bus.out_data);
            end else begin
                check("emit_order", bus.out_data, sb.pop_front());
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            sb.push_back(d);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base_acc;
        int base_emt;
        logic [3:0] bp [5];

        vecs[0] = '{4'b0001, MIX_PASS,     4'b0001};
        vecs[1] = '{4'b0001, MIX_ROTL,     4'b1000};
        vecs[2] = '{4'b0001, MIX_REV,      4'b1000};
        vecs[3] = '{4'b0001, MIX_PAIRSWAP, 4'b0010};
        vecs[4] = '{4'b1010, MIX_ROTL,     4'b0101};
        vecs[5] = '{4'b1100, MIX_REV,      4'b0011};
        vecs[6] = '{4'b0110, MIX_PAIRSWAP, 4'b1001};
        vecs[7] = '{4'b0111, MIX_ROTL,     4'b1011};
        bp[0] = 4'h3; bp[1] = 4'h5; bp[2] = 4'h9; bp[3] = 4'hC; bp[4] = 4'h6;

        // Reset held two cycles with a beat offered.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'hF;
        bus.mix_mode  = MIX_PASS;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_occupancy", bus.occupancy, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_busy",      bus.busy,      0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        base_emt = n_emt;
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1);
        check("rst_discard", n_emt - base_emt, 0);

        // Single-beat latency.
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b0001;
        bus.mix_mode  = MIX_PASS;
        bus.out_ready = 1'b1;
        #1;
        check("lat_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("lat_cycles", lat, 3);
        check("lat_out_data", bus.out_data, 4'b0001);
        tick();
        check("lat_single", bus.out_valid, 0);

        // Mode table streamed back to back; each beat carries its own mode.
        for (int t = 0; t < NVEC + 2; t++) begin
            if (t < NVEC) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vecs[t].data;
                bus.mix_mode = vecs[t].mode;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (t >= 2) begin
                check($sformatf("mode_valid_%0d", t - 2), bus.out_valid, 1);
                check($sformatf("mode_data_%0d", t - 2), bus.out_data, vecs[t-2].expect_out);
            end
        end
        tick();
        check("mode_drain", bus.out_valid, 0);

        // Backpressure: five offered, three fit, output frozen, then ordered drain.
        sb.delete();
        base_acc = n_acc;
        for (int i = 0; i < 5; i++) cycle(1'b1, bp[n_acc - base_acc], 1'b0);
        check("bp_accepted", n_acc - base_acc, 3);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_occupancy", bus.occupancy, 3);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_out_data", bus.out_data, 4'h3);
        cycle(1'b1, bp[3], 1'b0);
        cycle(1'b1, bp[3], 1'b0);
        check("bp_frozen", bus.out_data, 4'h3);
        check("bp_still_3", n_acc - base_acc, 3);
        base_emt = n_emt;
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1);
        check("bp_emitted", n_emt - base_emt, 3);
        check("bp_drained", sb.size(), 0);
        check("bp_empty_occ", bus.occupancy, 0);

        // Full pipe with simultaneous accept and emit.
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'hD, 1'b0);
        check("full_fill_occ", bus.occupancy, 3);
        base_acc = n_acc;
        base_emt = n_emt;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'(i), 1'b1);
            check("full_occ", bus.occupancy, 3);
        end
        check("full_accepted", n_acc - base_acc, 10);
        check("full_emitted", n_emt - base_emt, 10);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1);
        check("full_drained", sb.size(), 0);

        // Mid-flight reset with two beats inside.
        cycle(1'b1, 4'h7, 1'b0);
        cycle(1'b1, 4'hE, 1'b0);
        check("mid_occ_2", bus.occupancy, 2);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("mid_occ_0", bus.occupancy, 0);
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_busy", bus.busy, 0);
        rst = 1'b0;
        sb.delete();
        base_emt = n_emt;
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1);
        check("mid_no_emit", n_emt - base_emt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
